// File: rtl/gsplat_video_timing.sv
// gsplat_video_timing: raster timing generator.
// A pixel-enable divider drives horizontal/vertical counters, from which the
// blanking, data-enable and sync signals are decoded combinationally. It also
// produces registered frame-start and programmable line-interrupt pulses.
// Optional frame counter: define GSPLAT_VT_FRAMECNT_EN to build it; otherwise
// frame_cnt is tied to zero.
module gsplat_video_timing #(
  parameter int CE_DIV   = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] line_match,
  output logic          ce_pix,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic          hblank,
  output logic          vblank,
  output logic          frame_start,
  output logic          line_irq,
  output logic [15:0]   frame_cnt
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject geometries the counters cannot represent and illegal dividers.
  if (HT > (2 ** CW) || VT > (2 ** CW) || CE_DIV < 1 || CE_DIV > 16) begin : g_bad_cfg
    $error("gsplat_video_timing: HT/VT exceed 2**CW or CE_DIV outside 1..16");
  end

  localparam logic [3:0]  DIV_LAST = 4'(CE_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  // Decode thresholds are one bit wider so an edge value of 2**CW cannot alias.
  localparam logic [CW:0] H_ACT_E = (CW + 1)'(H_ACTIVE);
  localparam logic [CW:0] H_SS_E  = (CW + 1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SE_E  = (CW + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_E = (CW + 1)'(V_ACTIVE);
  localparam logic [CW:0] V_SS_E  = (CW + 1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SE_E  = (CW + 1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]    div_q, div_d;
  logic          ce_pix_q, ce_pix_d;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          frame_start_q, frame_start_d;
  logic          line_irq_q, line_irq_d;
  logic [CW:0]   hc_e, vc_e;
  logic          hsync_raw, vsync_raw;

  // Next-state: divider, raster counters and the wrap-derived pulses.
  // enable=0 freezes everything; the pending ce_pix is dropped, not replayed.
  always_comb begin
    div_d         = div_q;
    ce_pix_d      = 1'b0;
    hc_d          = hc_q;
    vc_d          = vc_q;
    frame_start_d = 1'b0;
    line_irq_d    = 1'b0;
    if (enable) begin
      div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      ce_pix_d = (div_q == DIV_LAST);
      if (ce_pix_q) begin
        if (hc_q == H_LAST) begin
          hc_d          = '0;
          vc_d          = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
          // Compared against the new line, so out-of-range targets never match.
          line_irq_d    = (vc_d == line_match);
          frame_start_d = (vc_q == V_LAST);
        end else begin
          hc_d = hc_q + CW'(1);
        end
      end
    end
  end

  // State register with synchronous reset that overrides enable.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
      line_irq_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
      line_irq_q    <= line_irq_d;
    end
  end

  // Zero-latency decode of blanking, data enable and sync from the counters.
  always_comb begin
    hc_e      = {1'b0, hc_q};
    vc_e      = {1'b0, vc_q};
    hblank    = (hc_e >= H_ACT_E);
    vblank    = (vc_e >= V_ACT_E);
    de        = ~(hblank | vblank);
    hsync_raw = (hc_e >= H_SS_E) && (hc_e < H_SE_E);
    vsync_raw = (vc_e >= V_SS_E) && (vc_e < V_SE_E);
    hs        = hsync_raw ^ HS_POL;
    vs        = vsync_raw ^ VS_POL;
  end

  assign ce_pix      = ce_pix_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign frame_start = frame_start_q;
  assign line_irq    = line_irq_q;

`ifdef GSPLAT_VT_FRAMECNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count completed frames; advances on the same edge that raises frame_start.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
